parallel_bus_capture: RTL and testbench
=======================================

// Module: parallel_bus_capture
// PURPOSE
//  Oversampling capture front-end for an 8080-style parallel LCD bus (data, RESET, CS, D/C, WR, RD).
//  Synchronises bus strobes into the clk domain and detects WR (and optionally RD) rising edges.
//  Each detected edge pushes one {ctrl, data} record into a DEPTH-entry FIFO.
//  A downstream viewer (seven-segment display or UART dumper) drains the FIFO via valid/ready.
// PARAMETERS
//  DATA_WIDTH   8  bus data width in bits (8 or 16 supported)
//  DEPTH        16 FIFO entries; power of two, >= 2
//  SYNC_STAGES  2  synchroniser flops per bus input; >= 2
// PORTS
//  clk            in   1                  system clock; all logic on posedge
//  nreset         in   1                  asynchronous, active-low reset
//  bus_data       in   DATA_WIDTH         bus data lines
//  bus_reset      in   1                  bus RESET line, sampled as-is
//  bus_cs         in   1                  bus chip select, active low
//  bus_dc         in   1                  bus data/command line
//  bus_wr         in   1                  bus write strobe, active low; capture on rising edge
//  bus_rd         in   1                  bus read strobe, active low; capture on rising edge
//  capture_en     in   1                  1 = capture enabled
//  rd_capture_en  in   1                  1 = also capture RD edges
//  cs_filter      in   1                  1 = ignore edges while synchronised bus_cs is high
//  clear_overflow in   1                  one-cycle pulse; clears overflow
//  out_ready      in   1                  consumer ready
//  out_valid      out  1                  head record available
//  out_data       out  DATA_WIDTH         head record data
//  out_ctrl       out  4                  head record {reset, cs, dc, is_read}
//  fill_level     out  $clog2(DEPTH)+1    entries held, 0..DEPTH
//  overflow       out  1                  sticky: a capture was dropped
// BEHAVIOUR
//  - Reset: all outputs 0. FIFO empty. Strobe synchronisers preset to 1 (idle), so leaving
//    reset with strobes high produces no edge. Data/ctrl synchronisers reset to 0.
//  - All bus inputs share one SYNC_STAGES chain, so data and strobes stay cycle-aligned.
//  - Edge: rising edge = last sync stage 1 and previous sample 0. The record uses the sample
//    from the cycle before the edge (last low-strobe sample), where data is stable.
//  - Qualify: edge counts only if capture_en = 1, and (cs_filter = 0 or sync cs = 0).
//    RD edges also require rd_capture_en = 1.
//  - Simultaneous WR and RD edges: WR record pushed; RD edge discarded; overflow unaffected.
//  - Latency: pin rising edge to out_valid is SYNC_STAGES+2 clk when FIFO was empty:
//    sync stages, then edge register, then FIFO write.
//  - Min strobe high and low width: 2 clk each. Narrower pulses may be missed; not flagged.
//  - Handshake: pop on the cycle with out_valid & out_ready.
//    out_data/out_ctrl hold steady while out_valid & !out_ready.
//    out_valid never drops without a pop.
//  - Full: a qualified edge with fill_level = DEPTH and no pop in that cycle is dropped and
//    sets overflow. Push and pop in the same cycle while full: both happen, no overflow.
//  - Empty: pop ignored. A push into an empty FIFO is visible on the next cycle (no fall-through).
//  - fill_level: +1 on push only, -1 on pop only, unchanged on both. Pointers wrap mod DEPTH.
//  - overflow: set has priority over clear_overflow in the same cycle.
//  - capture_en deassert: edge detection stops immediately; FIFO contents retained and still
//    drainable.
//  - nreset mid-operation: FIFO flushed, overflow cleared, no partial record delivered.
// STRUCTURE
//  - Package parallel_bus_pkg: CTRL_W = 4; field indices CTRL_RESET = 3, CTRL_CS = 2, CTRL_DC = 1,
//    CTRL_IS_READ = 0; record width helper REC_W(DATA_WIDTH) = DATA_WIDTH + CTRL_W.
//  - Sub-module sync_fifo (WIDTH, DEPTH): registered-output FIFO with push, pop, full, empty,
//    count; reused by other capture blocks.
//  - Top holds synchronisers, edge detect, qualify/arbitration and overflow logic.
// TESTING
//  - Single write: cs=0, dc=1, data=8'hA5, WR low 4 clk then high -> out_valid after
//    SYNC_STAGES+2 clk; out_data=A5, out_ctrl=4'b0010.
//  - Fill and overflow: out_ready=0, 17 writes of data 0..16 (DEPTH=16) -> fill_level=16,
//    overflow=1. Drain yields 0..15 in order; 16 is absent.
//  - Filters: cs=1, cs_filter=1, write 8'h11 -> nothing captured.
//    rd_capture_en=1, cs=0, RD pulse with 8'h3C -> out_ctrl[0]=1, out_data=3C.
//  - Simultaneous: WR and RD rise together with data 8'h77 -> one record, is_read=0,
//    fill_level=1.
//  - Back-pressure: out_ready toggled randomly over 100 writes -> every record delivered once,
//    in order; data stable while stalled.
//  - Reset mid-stream: 5 entries held, pulse nreset -> out_valid=0, fill_level=0, overflow=0;
//    no spurious capture on release with strobes high.

Source files
------------

// File: rtl/parallel_bus_pkg.sv
// Purpose: shared record layout for the parallel LCD bus capture blocks.
// Latency: n/a (types, constants and a width helper only).
// Backpressure: n/a.
package parallel_bus_pkg;

    localparam int CTRL_W       = 4;
    localparam int CTRL_RESET   = 3;
    localparam int CTRL_CS      = 2;
    localparam int CTRL_DC      = 1;
    localparam int CTRL_IS_READ = 0;

    // Field order matches the CTRL_* bit indices above.
    typedef struct packed {
        logic reset;
        logic cs;
        logic dc;
        logic is_read;
    } ctrl_t;

    // Width of one {ctrl, data} record.
    function automatic int REC_W(input int data_width);
        return data_width + CTRL_W;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Purpose: single-clock FIFO whose head is always driven from storage flops.
// Latency: push visible at pop_dat one cycle later; no fall-through.
// Backpressure: push is ignored when full unless a pop happens in the same cycle.
// Ports: push/push_dat write side, pop/pop_dat read side (head), full, empty,
//        count = entries held (0..DEPTH).
module sync_fifo #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     nreset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_dat,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_dat,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (cnt == CW'(DEPTH));
    assign empty   = (cnt == '0);
    assign pop_ok  = pop & ~empty;
    // When full, a simultaneous pop frees the head slot, which is exactly
    // the slot wr_ptr points at, so the write can proceed.
    assign push_ok = push & (~full | pop_ok);

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    assign pop_dat = mem[rd_ptr];
    assign count   = cnt;

endmodule

// File: rtl/parallel_bus_capture.sv
// Purpose: oversampled capture of 8080-style LCD bus writes (and optionally reads) into a FIFO.
// Latency: pin strobe rising edge to out_valid = SYNC_STAGES+2 clk when the FIFO is empty.
// Backpressure: out_valid/out_ready; captures arriving while full are dropped and flag overflow.
// Ports: bus_* raw bus pins; capture_en, rd_capture_en, cs_filter, clear_overflow control;
//        out_valid/out_ready/out_data/out_ctrl head record {reset,cs,dc,is_read};
//        fill_level entries held; overflow sticky drop flag.
module parallel_bus_capture
    import parallel_bus_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int DEPTH       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                     clk,
    input  logic                     nreset,
    input  logic [DATA_WIDTH-1:0]    bus_data,
    input  logic                     bus_reset,
    input  logic                     bus_cs,
    input  logic                     bus_dc,
    input  logic                     bus_wr,
    input  logic                     bus_rd,
    input  logic                     capture_en,
    input  logic                     rd_capture_en,
    input  logic                     cs_filter,
    input  logic                     clear_overflow,
    input  logic                     out_ready,
    output logic                     out_valid,
    output logic [DATA_WIDTH-1:0]    out_data,
    output logic [CTRL_W-1:0]        out_ctrl,
    output logic [$clog2(DEPTH):0]   fill_level,
    output logic                     overflow
);

    localparam int RW = REC_W(DATA_WIDTH);
    localparam int SW = DATA_WIDTH + 5;

    // Bit positions inside the synchronised bus vector.
    localparam int S_RD  = 0;
    localparam int S_WR  = 1;
    localparam int S_DC  = 2;
    localparam int S_CS  = 3;
    localparam int S_RST = 4;
    localparam int S_DAT = 5;

    // Strobes idle high so that leaving reset with them high is not an edge;
    // data and control lines come up as zero.
    localparam logic [SW-1:0] SYNC_IDLE = SW'(2'b11);

    logic [SW-1:0] bus_vec;
    logic [SW-1:0] sync_q [SYNC_STAGES];
    logic [SW-1:0] prev_q;

    logic          wr_rise;
    logic          rd_rise;
    logic          cs_ok;
    logic          wr_cap;
    logic          rd_cap;
    ctrl_t         rec_ctrl;

    logic          edge_vld_q;
    logic [RW-1:0] edge_rec_q;

    logic          fifo_pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic [RW-1:0] fifo_head;
    logic          drop;

    // One shared chain keeps data and strobes cycle-aligned.
    assign bus_vec = {bus_data, bus_reset, bus_cs, bus_dc, bus_wr, bus_rd};

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= SYNC_IDLE;
            end
            prev_q <= SYNC_IDLE;
        end else begin
            sync_q[0] <= bus_vec;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign wr_rise = sync_q[SYNC_STAGES-1][S_WR] & ~prev_q[S_WR];
    assign rd_rise = sync_q[SYNC_STAGES-1][S_RD] & ~prev_q[S_RD];
    assign cs_ok   = ~cs_filter | ~sync_q[SYNC_STAGES-1][S_CS];

    // WR wins when both strobes rise together; the RD edge is simply discarded.
    assign wr_cap  = capture_en & cs_ok & wr_rise;
    assign rd_cap  = capture_en & cs_ok & rd_capture_en & rd_rise & ~wr_cap;

    // The record is taken from the last low-strobe sample, where data is settled.
    always_comb begin
        rec_ctrl         = '0;
        rec_ctrl.reset   = prev_q[S_RST];
        rec_ctrl.cs      = prev_q[S_CS];
        rec_ctrl.dc      = prev_q[S_DC];
        rec_ctrl.is_read = ~wr_cap;
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            edge_vld_q <= 1'b0;
            edge_rec_q <= '0;
        end else begin
            edge_vld_q <= wr_cap | rd_cap;
            if (wr_cap | rd_cap) begin
                edge_rec_q <= {rec_ctrl, prev_q[SW-1:S_DAT]};
            end
        end
    end

    assign fifo_pop = ~fifo_empty & out_ready;
    assign drop     = edge_vld_q & fifo_full & ~fifo_pop;

    sync_fifo #(
        .WIDTH (RW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .nreset   (nreset),
        .push     (edge_vld_q),
        .push_dat (edge_rec_q),
        .pop      (fifo_pop),
        .pop_dat  (fifo_head),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fill_level)
    );

    // A drop in the same cycle as a clear request leaves the flag set.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (clear_overflow) begin
            overflow <= 1'b0;
        end
    end

    assign out_valid = ~fifo_empty;
    assign out_ctrl  = fifo_head[RW-1:DATA_WIDTH];
    assign out_data  = fifo_head[DATA_WIDTH-1:0];

endmodule

// File: tb/tb_parallel_bus_capture.sv
module tb_parallel_bus_capture;

    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int SS    = 2;

    logic          clk = 1'b0;
    logic          nreset;
    logic [DW-1:0] bus_data;
    logic          bus_reset, bus_cs, bus_dc, bus_wr, bus_rd;
    logic          capture_en, rd_capture_en, cs_filter, clear_overflow;
    logic          out_ready = 1'b0;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic [3:0]    out_ctrl;
    logic [4:0]    fill_level;
    logic          overflow;

    parallel_bus_capture #(
        .DATA_WIDTH  (DW),
        .DEPTH       (DEPTH),
        .SYNC_STAGES (SS)
    ) dut (
        .clk            (clk),
        .nreset         (nreset),
        .bus_data       (bus_data),
        .bus_reset      (bus_reset),
        .bus_cs         (bus_cs),
        .bus_dc         (bus_dc),
        .bus_wr         (bus_wr),
        .bus_rd         (bus_rd),
        .capture_en     (capture_en),
        .rd_capture_en  (rd_capture_en),
        .cs_filter      (cs_filter),
        .clear_overflow (clear_overflow),
        .out_ready      (out_ready),
        .out_valid      (out_valid),
        .out_data       (out_data),
        .out_ctrl       (out_ctrl),
        .fill_level     (fill_level),
        .overflow       (overflow)
    );

    always #5 clk = ~clk;

    logic [11:0] exp_q[$];
    logic [11:0] exp_rec;
    logic [11:0] held;
    bit          stall = 1'b0;
    int          checks = 0;
    int          errors = 0;
    int          ready_mode = 0;   // 0: hold low, 1: hold high, 2: random

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       out_ready = 1'b0;
            1:       out_ready = 1'b1;
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Monitor: compares every delivered record with the scoreboard and
    // checks the head stays put while stalled.
    always @(negedge clk) begin
        if (!nreset) begin
            stall = 1'b0;
        end else begin
            if (stall) begin
                if (!out_valid) begin
                    checks++;
                    errors++;
                    $display("FAIL valid_drop: out_valid fell without a pop at %0t", $time);
                end else begin
                    chk("stall_hold", 32'({out_ctrl, out_data}), 32'(held));
                end
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_record: got %0h with nothing expected at %0t",
                             {out_ctrl, out_data}, $time);
                end else begin
                    exp_rec = exp_q.pop_front();
                    chk("record", 32'({out_ctrl, out_data}), 32'(exp_rec));
                end
                stall = 1'b0;
            end else if (out_valid) begin
                stall = 1'b1;
                held  = {out_ctrl, out_data};
            end else begin
                stall = 1'b0;
            end
        end
    end

    // One bus cycle: strobe(s) low 4 clk, then high 4 clk.
    task automatic strobe(input logic [7:0] d, input logic dc, input logic cs, input logic rst,
                          input logic do_wr, input logic do_rd, input bit expect_rec,
                          input logic is_rd);
        bus_data  = d;
        bus_dc    = dc;
        bus_cs    = cs;
        bus_reset = rst;
        if (do_wr) bus_wr = 1'b0;
        if (do_rd) bus_rd = 1'b0;
        tick(4);
        bus_wr = 1'b1;
        bus_rd = 1'b1;
        if (expect_rec) exp_q.push_back({rst, cs, dc, is_rd, d});
        tick(4);
    endtask

    task automatic drain();
        ready_mode = 1;
        for (int i = 0; i < 400 && (exp_q.size() != 0 || out_valid); i++) tick(1);
        chk("drain_queue_empty", 32'(exp_q.size()), 32'd0);
        chk("drain_fill_zero", 32'(fill_level), 32'd0);
        ready_mode = 0;
        tick(2);
    endtask

    initial begin
        nreset = 1'b0;
        bus_data = '0; bus_reset = 1'b0; bus_cs = 1'b0; bus_dc = 1'b0;
        bus_wr = 1'b1; bus_rd = 1'b1;
        capture_en = 1'b1; rd_capture_en = 1'b0; cs_filter = 1'b0; clear_overflow = 1'b0;
        tick(3);

        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_fill_level", 32'(fill_level), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_ctrl", 32'(out_ctrl), 32'd0);
        tick(1);
        nreset = 1'b1;
        tick(6);
        @(negedge clk);
        chk("release_no_edge", 32'(fill_level), 32'd0);

        // Single write and latency.
        tick(1);
        bus_data = 8'hA5; bus_dc = 1'b1; bus_cs = 1'b0; bus_wr = 1'b0;
        tick(4);
        bus_wr = 1'b1;
        exp_q.push_back({4'b0010, 8'hA5});
        repeat (SS + 1) @(posedge clk);
        @(negedge clk);
        chk("latency_early", 32'(out_valid), 32'd0);
        @(negedge clk);
        chk("latency_on_time", 32'(out_valid), 32'd1);
        drain();

        // CS filter, unfiltered CS-high write, RD with and without enable.
        cs_filter = 1'b1;
        strobe(8'h11, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("cs_filtered", 32'(fill_level), 32'd0);
        cs_filter = 1'b0;
        strobe(8'h22, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        strobe(8'h33, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        chk("rd_disabled", 32'(fill_level), 32'd1);
        rd_capture_en = 1'b1;
        cs_filter = 1'b1;
        strobe(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        @(negedge clk);
        chk("rd_captured", 32'(fill_level), 32'd2);
        drain();

        // WR and RD rising together.
        strobe(8'h77, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        chk("simul_fill", 32'(fill_level), 32'd1);
        drain();
        cs_filter = 1'b0;

        // Capture disabled.
        capture_en = 1'b0;
        strobe(8'h55, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("capture_disabled", 32'(fill_level), 32'd0);
        capture_en = 1'b1;

        // Fill past DEPTH.
        for (int i = 0; i <= DEPTH; i++)
            strobe(8'(i), 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, i < DEPTH, 1'b0);
        @(negedge clk);
        chk("full_fill_level", 32'(fill_level), 32'd16);
        chk("full_overflow", 32'(overflow), 32'd1);
        drain();
        chk("overflow_sticky", 32'(overflow), 32'd1);

        // Reset with entries held and overflow set.
        for (int i = 0; i < 5; i++)
            strobe(8'(8'h40 + i), 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        chk("pre_reset_fill", 32'(fill_level), 32'd5);
        tick(1);
        nreset = 1'b0;
        exp_q.delete();
        @(negedge clk);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_fill", 32'(fill_level), 32'd0);
        chk("midrst_overflow", 32'(overflow), 32'd0);
        tick(2);
        nreset = 1'b1;
        tick(8);
        @(negedge clk);
        chk("post_reset_fill", 32'(fill_level), 32'd0);
        chk("post_reset_valid", 32'(out_valid), 32'd0);

        // Overflow clear.
        for (int i = 0; i <= DEPTH; i++)
            strobe(8'(8'h80 + i), 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, i < DEPTH, 1'b0);
        @(negedge clk);
        chk("refill_overflow", 32'(overflow), 32'd1);
        tick(1);
        clear_overflow = 1'b1;
        tick(1);
        clear_overflow = 1'b0;
        @(negedge clk);
        chk("overflow_cleared", 32'(overflow), 32'd0);
        drain();

        // Random back-pressure over 100 writes.
        ready_mode = 2;
        for (int i = 0; i < 100; i++) begin
            logic [7:0] v;
            v = 8'(i);
            strobe(v, v[0], 1'b0, v[1], 1'b1, 1'b0, 1'b1, 1'b0);
        end
        drain();
        chk("bp_no_overflow", 32'(overflow), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
